pet_status: RTL and testbench
=============================

# pet_status

Game-state datapath for the virtual pet. Sits directly upstream of the draw/sequencing FSM: it counts frame ticks, ages the pet's needs (hunger, boredom, dirt, sickness), tracks health and the sleep cycle, and latches player item requests. It produces the need enables, the `*Given` item levels and `deceased` that the FSM samples after each background redraw.

## Interface
- `TICKS_PER_STEP`, 30: `frameTick` pulses per need-aging step.
- `BORED_DIV`, 2: boredom increments every BORED_DIV steps.
- `DIRTY_DIV`, 3: dirt increments every DIRTY_DIV steps.
- `NEED_THRESH`, 8: level at or above which a need enable asserts.
- `DYING_THRESH`, 4: health at or below which `dyingEnable` asserts.
- `AWAKE_STEPS`, 40 and `SLEEP_STEPS`, 10: lengths of the sleep cycle, in steps.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low; 0 on a rising `clk` resets the block.
- frameTick  in  1  one-cycle pulse per video frame.
- playBtn, feedBtn, cleanBtn, medsBtn, aidBtn  in  1 each  debounced one-cycle player requests.
- itemDone  in  1  one-cycle pulse; the item animation has finished and its effect applies.
- ballGiven, foodGiven, broomGiven, pillsGiven, firstAidGiven  out  1 each  pending item; at most one is high.
- hungerEnable, boredEnable, sickEnable, dirtyEnable, dyingEnable, zzzsEnable  out  1 each  need indicators.
- deceased  out  1  sticky death flag.
- health  out  4  current health, 0..15.

## Operation
- **Reset values.** All need levels 0, health 15, awake, all counters 0, all outputs 0 except `health` = 15.
- **Step generator.** A tick counter runs 0..TICKS_PER_STEP-1 on `frameTick` and wraps. `step` pulses on the cycle the counter wraps.
- **Needs.** Hunger, boredom, dirt and sickness are 4-bit levels that saturate at 15.
  - While awake and not deceased, on `step`: hunger +1. Boredom +1 every BORED_DIV-th step. Dirt +1 every DIRTY_DIV-th step. Sickness +1 if dirt ≥ NEED_THRESH.
  - Each need enable is `level ≥ NEED_THRESH`.
- **Health.** On `step`, while awake, if any need equals 15, health decrements by 1.
  - `dyingEnable` = `health ≤ DYING_THRESH` and not deceased.
  - When health reaches 0, `deceased` sets and stays set until reset. Once set: all levels freeze, the pending item clears, and buttons are ignored.
- **Sleep.** A step counter alternates awake (AWAKE_STEPS) and asleep (SLEEP_STEPS). `zzzsEnable` = asleep.
  - While asleep, needs and health do not change and buttons are ignored.
- **Item FSM.** States IDLE and PENDING.
  - IDLE: a button press (awake, not deceased) latches the matching item and moves to PENDING. If several buttons are pressed in the same cycle, priority is play > feed > clean > meds > aid.
  - PENDING: buttons are ignored. `itemDone` applies the effect and returns to IDLE. Effects: ball clears boredom, food clears hunger, broom clears dirt, pills clear sickness, first aid sets health to 15.
  - `itemDone` in IDLE is ignored.

## Timing
- All outputs are registered.
- A `*Given` output goes high the cycle after its button pulse.
- An effect is visible the cycle after `itemDone`; the `*Given` output drops on that same edge.
- A need enable updates one cycle after the `step` that crosses its threshold.
- Simultaneous `itemDone` and `step`: the item effect wins for the affected quantity (cleared to 0 or set to 15, no increment or decrement that cycle). Other quantities age normally.
- The cycle in which health reaches 0 sets `deceased` and clears any pending item, even if `itemDone` arrives in the same cycle.
- Reset mid-operation: every state returns to its reset value on the next edge, including a pending item and `deceased`.
- A `frameTick` that lands in the reset cycle is not counted.

## Structure
- Package `pet_pkg` holds:
  - the level width (4) and LEVEL_MAX = 15;
  - the item enum {NONE, BALL, FOOD, BROOM, PILLS, FIRSTAID};
  - the default threshold constants.
- One sub-module, `need_counter`: a 4-bit saturating counter with `inc`, `clr` and `hold` inputs (clr wins over inc). Instantiated four times.
- Step generator, sleep cycle, health and item FSM stay in `pet_status`.

## Test plan
All scenarios use TICKS_PER_STEP=2, BORED_DIV=2, DIRTY_DIV=3, AWAKE_STEPS=40, SLEEP_STEPS=10, and a frameTick every 4 cycles.
- **Reset.** Hold `reset`=0 for 3 cycles -> all outputs 0, `health` = 15. Release -> no change until the first `step`.
- **Need thresholds.** 16 `frameTick`s (8 steps) -> hunger 8, `hungerEnable`=1. Boredom 4, `boredEnable`=0. Dirt 2.
- **Item priority and lifecycle.** `feedBtn` and `cleanBtn` in the same cycle -> `foodGiven`=1 only. `playBtn` while pending -> ignored. `itemDone` -> `foodGiven`=0 and hunger 0 on the next cycle.
- **Simultaneous `itemDone` and `step` with hunger 9.** -> hunger 0, not 10.
- **Sleep.** Let 40 steps elapse -> `zzzsEnable`=1, levels frozen for 10 steps, `feedBtn` ignored. Then `zzzsEnable`=0 and aging resumes.
- **Death.** Let hunger saturate and health drain -> `dyingEnable` at `health` = 4, `deceased`=1 at 0, `aidBtn` ignored. Assert `reset`=0 -> `deceased`=0, `health` = 15.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared types and constants for the virtual-pet game-state datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pet_pkg;

   localparam int LVL_W = 4;
   typedef logic [LVL_W-1:0] level_t;
   localparam level_t LEVEL_MAX = 4'd15;

   typedef enum logic [2:0] {
      NONE,
      BALL,
      FOOD,
      BROOM,
      PILLS,
      FIRSTAID
   } item_e;

   typedef enum logic {
      IDLE,
      PENDING
   } item_st_e;

   localparam int DEF_TICKS_PER_STEP = 30;
   localparam int DEF_BORED_DIV      = 2;
   localparam int DEF_DIRTY_DIV      = 3;
   localparam int DEF_NEED_THRESH    = 8;
   localparam int DEF_DYING_THRESH   = 4;
   localparam int DEF_AWAKE_STEPS    = 40;
   localparam int DEF_SLEEP_STEPS    = 10;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/need_counter.sv
// Saturating 4-bit need level with registered threshold enable.
// Latency: level and enable both update on the edge after inc/clr.
// Backpressure: none; clr beats hold beats inc, inc saturates at LEVEL_MAX.
module need_counter
   import pet_pkg::*;
#(
   parameter int THRESH = DEF_NEED_THRESH
)(
   input  logic   clk,
   input  logic   reset,
   input  logic   inc,
   input  logic   clr,
   input  logic   hold,
   output level_t level,
   output logic   en
);

   localparam level_t THR_L = level_t'(THRESH);

   level_t level_q, level_d;
   logic   en_q, en_d;

   // Next level: item effect clears even while frozen, aging only when not held.
   always_comb begin
      level_d = level_q;
      if (clr) begin
         level_d = '0;
      end else if (hold) begin
         level_d = level_q;
      end else if (inc && (level_q != LEVEL_MAX)) begin
         level_d = level_q + 4'd1;
      end
      en_d = (level_d >= THR_L);
   end

   // Level and enable registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         level_q <= '0;
         en_q    <= 1'b0;
      end else begin
         level_q <= level_d;
         en_q    <= en_d;
      end
   end

   assign level = level_q;
   assign en    = en_q;

endmodule

// File: rtl/pet_status.sv
// Pet game state: step generator, need aging, health, sleep cycle, item requests.
// Latency: every output registered; effects visible the edge after the causing pulse.
// Backpressure: none; buttons are dropped while pending, asleep or deceased.
module pet_status
   import pet_pkg::*;
#(
   parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
   parameter int BORED_DIV      = DEF_BORED_DIV,
   parameter int DIRTY_DIV      = DEF_DIRTY_DIV,
   parameter int NEED_THRESH    = DEF_NEED_THRESH,
   parameter int DYING_THRESH   = DEF_DYING_THRESH,
   parameter int AWAKE_STEPS    = DEF_AWAKE_STEPS,
   parameter int SLEEP_STEPS    = DEF_SLEEP_STEPS
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       frameTick,
   input  logic       playBtn,
   input  logic       feedBtn,
   input  logic       cleanBtn,
   input  logic       medsBtn,
   input  logic       aidBtn,
   input  logic       itemDone,
   output logic       ballGiven,
   output logic       foodGiven,
   output logic       broomGiven,
   output logic       pillsGiven,
   output logic       firstAidGiven,
   output logic       hungerEnable,
   output logic       boredEnable,
   output logic       sickEnable,
   output logic       dirtyEnable,
   output logic       dyingEnable,
   output logic       zzzsEnable,
   output logic       deceased,
   output logic [3:0] health
);

   localparam int TW = cnt_w(TICKS_PER_STEP);
   localparam int BW = cnt_w(BORED_DIV);
   localparam int DW = cnt_w(DIRTY_DIV);
   localparam int SW = cnt_w((AWAKE_STEPS > SLEEP_STEPS) ? AWAKE_STEPS : SLEEP_STEPS);

   localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_STEP - 1);
   localparam logic [BW-1:0] BORED_LAST = BW'(BORED_DIV - 1);
   localparam logic [DW-1:0] DIRTY_LAST = DW'(DIRTY_DIV - 1);
   localparam logic [SW-1:0] AWAKE_LAST = SW'(AWAKE_STEPS - 1);
   localparam logic [SW-1:0] SLEEP_LAST = SW'(SLEEP_STEPS - 1);
   localparam level_t        NEED_L     = level_t'(NEED_THRESH);
   localparam level_t        DYING_L    = level_t'(DYING_THRESH);

   logic [TW-1:0] tick_q, tick_d;
   logic [BW-1:0] bdiv_q, bdiv_d;
   logic [DW-1:0] ddiv_q, ddiv_d;
   logic [SW-1:0] slp_q, slp_d;
   logic          asleep_q, asleep_d;
   level_t        health_q, health_d;
   logic          deceased_q, deceased_d;
   logic          dying_q, dying_d;
   item_st_e      st_q, st_d;
   item_e         item_q, item_d;
   logic [4:0]    given_q, given_d;

   logic   step, age, hold;
   logic   bored_inc, dirt_inc, sick_inc;
   logic   done_fire, any_max, health_dec;
   logic   clr_hunger, clr_bored, clr_dirt, clr_sick;
   level_t hunger_lvl, bored_lvl, dirt_lvl, sick_lvl;

   // Frame tick divider, aging dividers and the awake/asleep step counter.
   always_comb begin
      step   = frameTick && (tick_q == TICK_LAST);
      age    = step && !asleep_q && !deceased_q;
      hold   = asleep_q || deceased_q;

      tick_d = tick_q;
      if (frameTick) begin
         tick_d = step ? '0 : tick_q + TW'(1);
      end

      bdiv_d    = bdiv_q;
      ddiv_d    = ddiv_q;
      bored_inc = age && (bdiv_q == BORED_LAST);
      dirt_inc  = age && (ddiv_q == DIRTY_LAST);
      sick_inc  = age && (dirt_lvl >= NEED_L);
      if (age) begin
         bdiv_d = bored_inc ? '0 : bdiv_q + BW'(1);
         ddiv_d = dirt_inc  ? '0 : ddiv_q + DW'(1);
      end

      slp_d    = slp_q;
      asleep_d = asleep_q;
      if (step) begin
         if (asleep_q) begin
            if (slp_q == SLEEP_LAST) begin
               slp_d    = '0;
               asleep_d = 1'b0;
            end else begin
               slp_d = slp_q + SW'(1);
            end
         end else begin
            if (slp_q == AWAKE_LAST) begin
               slp_d    = '0;
               asleep_d = 1'b1;
            end else begin
               slp_d = slp_q + SW'(1);
            end
         end
      end
   end

   // Health, death latch and the item request state machine.
   always_comb begin
      done_fire  = (st_q == PENDING) && itemDone;
      clr_hunger = done_fire && (item_q == FOOD);
      clr_bored  = done_fire && (item_q == BALL);
      clr_dirt   = done_fire && (item_q == BROOM);
      clr_sick   = done_fire && (item_q == PILLS);

      any_max    = (hunger_lvl == LEVEL_MAX) || (bored_lvl == LEVEL_MAX) ||
                   (dirt_lvl == LEVEL_MAX)   || (sick_lvl == LEVEL_MAX);
      health_dec = age && any_max && (health_q != '0);

      health_d = health_q;
      if (done_fire && (item_q == FIRSTAID)) begin
         health_d = LEVEL_MAX;
      end else if (health_dec) begin
         health_d = health_q - 4'd1;
      end
      deceased_d = deceased_q || (health_d == '0);
      dying_d    = (health_d <= DYING_L) && !deceased_d;

      st_d   = st_q;
      item_d = item_q;
      case (st_q)
         IDLE: begin
            if (!asleep_q && !deceased_q) begin
               st_d = PENDING;
               if (playBtn)       item_d = BALL;
               else if (feedBtn)  item_d = FOOD;
               else if (cleanBtn) item_d = BROOM;
               else if (medsBtn)  item_d = PILLS;
               else if (aidBtn)   item_d = FIRSTAID;
               else               st_d   = IDLE;
            end
         end
         PENDING: begin
            if (itemDone) begin
               st_d   = IDLE;
               item_d = NONE;
            end
         end
         default: begin
            st_d   = IDLE;
            item_d = NONE;
         end
      endcase
      // Death on this edge drops any request, even one finishing right now.
      if (deceased_d) begin
         st_d   = IDLE;
         item_d = NONE;
      end

      given_d = {item_d == BALL, item_d == FOOD, item_d == BROOM,
                 item_d == PILLS, item_d == FIRSTAID};
   end

   // All block state and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_q     <= '0;
         bdiv_q     <= '0;
         ddiv_q     <= '0;
         slp_q      <= '0;
         asleep_q   <= 1'b0;
         health_q   <= LEVEL_MAX;
         deceased_q <= 1'b0;
         dying_q    <= 1'b0;
         st_q       <= IDLE;
         item_q     <= NONE;
         given_q    <= '0;
      end else begin
         tick_q     <= tick_d;
         bdiv_q     <= bdiv_d;
         ddiv_q     <= ddiv_d;
         slp_q      <= slp_d;
         asleep_q   <= asleep_d;
         health_q   <= health_d;
         deceased_q <= deceased_d;
         dying_q    <= dying_d;
         st_q       <= st_d;
         item_q     <= item_d;
         given_q    <= given_d;
      end
   end

   need_counter #(.THRESH(NEED_THRESH)) u_hunger (
      .clk(clk), .reset(reset), .inc(age), .clr(clr_hunger), .hold(hold),
      .level(hunger_lvl), .en(hungerEnable)
   );

   need_counter #(.THRESH(NEED_THRESH)) u_bored (
      .clk(clk), .reset(reset), .inc(bored_inc), .clr(clr_bored), .hold(hold),
      .level(bored_lvl), .en(boredEnable)
   );

   need_counter #(.THRESH(NEED_THRESH)) u_dirt (
      .clk(clk), .reset(reset), .inc(dirt_inc), .clr(clr_dirt), .hold(hold),
      .level(dirt_lvl), .en(dirtyEnable)
   );

   need_counter #(.THRESH(NEED_THRESH)) u_sick (
      .clk(clk), .reset(reset), .inc(sick_inc), .clr(clr_sick), .hold(hold),
      .level(sick_lvl), .en(sickEnable)
   );

   assign {ballGiven, foodGiven, broomGiven, pillsGiven, firstAidGiven} = given_q;
   assign dyingEnable = dying_q;
   assign zzzsEnable  = asleep_q;
   assign deceased    = deceased_q;
   assign health      = health_q;

endmodule

// File: tb/tb_pet_status.sv
// Bench for pet_status with fast step timing (2 ticks/step, tick every 4 cycles).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; stimulus is cycle-scheduled pulses.
module tb_pet_status;

   logic       clk = 1'b0;
   logic       reset, frameTick, playBtn, feedBtn, cleanBtn, medsBtn, aidBtn, itemDone;
   logic       ballGiven, foodGiven, broomGiven, pillsGiven, firstAidGiven;
   logic       hungerEnable, boredEnable, sickEnable, dirtyEnable, dyingEnable, zzzsEnable;
   logic       deceased;
   logic [3:0] health;
   logic [15:0] obs;

   always #5 clk = ~clk;

   pet_status #(
      .TICKS_PER_STEP(2), .BORED_DIV(2), .DIRTY_DIV(3), .NEED_THRESH(8),
      .DYING_THRESH(4), .AWAKE_STEPS(40), .SLEEP_STEPS(10)
   ) dut (
      .clk(clk), .reset(reset), .frameTick(frameTick),
      .playBtn(playBtn), .feedBtn(feedBtn), .cleanBtn(cleanBtn),
      .medsBtn(medsBtn), .aidBtn(aidBtn), .itemDone(itemDone),
      .ballGiven(ballGiven), .foodGiven(foodGiven), .broomGiven(broomGiven),
      .pillsGiven(pillsGiven), .firstAidGiven(firstAidGiven),
      .hungerEnable(hungerEnable), .boredEnable(boredEnable), .sickEnable(sickEnable),
      .dirtyEnable(dirtyEnable), .dyingEnable(dyingEnable), .zzzsEnable(zzzsEnable),
      .deceased(deceased), .health(health)
   );

   // {given[4:0] play..aid, enables hunger,bored,sick,dirty,dying,zzz, deceased, health}
   assign obs = {ballGiven, foodGiven, broomGiven, pillsGiven, firstAidGiven,
                 hungerEnable, boredEnable, sickEnable, dirtyEnable, dyingEnable,
                 zzzsEnable, deceased, health};

   typedef struct {
      logic [15:0] exp;
      string       name;
   } sb_t;

   typedef struct {
      int          at;
      int          chk;
      logic [4:0]  btn;
      logic        done;
      logic [15:0] exp;
      string       name;
   } vec_t;

   sb_t  sbq[$];
   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   localparam logic [4:0] B_PLAY  = 5'b10000;
   localparam logic [4:0] B_FEED  = 5'b01000;
   localparam logic [4:0] B_CLEAN = 5'b00100;
   localparam logic [4:0] B_MEDS  = 5'b00010;
   localparam logic [4:0] B_AID   = 5'b00001;

   task automatic drive(input logic [4:0] b, input logic d);
      frameTick = (cyc % 4 == 0);
      {playBtn, feedBtn, cleanBtn, medsBtn, aidBtn} = b;
      itemDone = d;
      @(posedge clk);
      #1;
      frameTick = 1'b0;
      {playBtn, feedBtn, cleanBtn, medsBtn, aidBtn} = 5'b0;
      itemDone = 1'b0;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc <= n) drive(5'b0, 1'b0);
   endtask

   task automatic expect_out(input logic [15:0] e, input string nm);
      sb_t s;
      s.exp  = e;
      s.name = nm;
      sbq.push_back(s);
   endtask

   task automatic check_out();
      sb_t s;
      total++;
      if (sbq.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty: got %h want <entry>", obs);
      end else begin
         s = sbq.pop_front();
         if (obs !== s.exp) begin
            bad++;
            $display("FAIL %s: cycle %0d got %h want %h", s.name, cyc - 1, obs, s.exp);
         end
      end
   endtask

   // Pulse btn/done at cycle 'at' (skipped when at < 0), then compare after cycle 'chk'.
   task automatic pulse_chk(input int at, input logic [4:0] b, input logic d,
                            input int chk, input logic [15:0] e, input string nm);
      expect_out(e, nm);
      if (at >= 0) begin
         run_to(at - 1);
         drive(b, d);
      end
      run_to(chk);
      check_out();
   endtask

   // Three reset cycles with every input active; a frame tick in the last one.
   task automatic do_reset(input string nm);
      for (int i = 0; i < 3; i++) begin
         reset     = 1'b0;
         frameTick = (i == 2);
         {playBtn, feedBtn, cleanBtn, medsBtn, aidBtn} = 5'b11111;
         itemDone  = 1'b1;
         expect_out(16'h000F, nm);
         @(posedge clk);
         #1;
         check_out();
      end
      reset     = 1'b1;
      frameTick = 1'b0;
      {playBtn, feedBtn, cleanBtn, medsBtn, aidBtn} = 5'b0;
      itemDone  = 1'b0;
      cyc       = 0;
   endtask

   // Eight cycles feeding, playing, cleaning and medicating back to back.
   task automatic refresh(input int s);
      run_to(s - 1);
      drive(B_FEED, 1'b0);  drive(5'b0, 1'b1);
      drive(B_PLAY, 1'b0);  drive(5'b0, 1'b1);
      drive(B_CLEAN, 1'b0); drive(5'b0, 1'b1);
      drive(B_MEDS, 1'b0);  drive(5'b0, 1'b1);
   endtask

   function automatic vec_t mk(input int at, input int chk, input logic [4:0] b,
                               input logic d, input logic [15:0] e, input string nm);
      vec_t v;
      v.at = at; v.chk = chk; v.btn = b; v.done = d; v.exp = e; v.name = nm;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, want $finish earlier");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; frameTick = 1'b0; itemDone = 1'b0;
      {playBtn, feedBtn, cleanBtn, medsBtn, aidBtn} = 5'b0;

      // Steps land on cycles 8k-4 after reset release.
      tbl.push_back(mk(-1,   0, 5'b0,    1'b0, 16'h000F, "first_tick"));
      tbl.push_back(mk(-1,   3, 5'b0,    1'b0, 16'h000F, "pre_step"));
      tbl.push_back(mk(-1,  59, 5'b0,    1'b0, 16'h000F, "hunger7"));
      tbl.push_back(mk(-1,  60, 5'b0,    1'b0, 16'h040F, "hunger8_en"));
      tbl.push_back(mk(62,  62, 5'b01100, 1'b0, 16'h440F, "feed_over_clean"));
      tbl.push_back(mk(64,  64, B_PLAY,  1'b0, 16'h440F, "play_while_pend"));
      tbl.push_back(mk(66,  66, 5'b0,    1'b1, 16'h000F, "food_done"));
      tbl.push_back(mk(70,  70, 5'b00111, 1'b0, 16'h200F, "clean_over_meds"));
      tbl.push_back(mk(72,  72, 5'b0,    1'b1, 16'h000F, "broom_done"));
      tbl.push_back(mk(74,  74, 5'b00011, 1'b0, 16'h100F, "meds_over_aid"));
      tbl.push_back(mk(76,  76, 5'b0,    1'b1, 16'h000F, "pills_done"));
      tbl.push_back(mk(78,  78, B_AID,   1'b0, 16'h080F, "aid_given"));
      tbl.push_back(mk(80,  80, 5'b0,    1'b1, 16'h000F, "aid_done"));
      tbl.push_back(mk(82,  82, 5'b11111, 1'b0, 16'h800F, "play_over_all"));
      tbl.push_back(mk(84,  84, 5'b0,    1'b1, 16'h000F, "ball_done_step"));
      tbl.push_back(mk(86,  86, 5'b0,    1'b1, 16'h000F, "done_idle"));
      tbl.push_back(mk(-1, 132, 5'b0,    1'b0, 16'h040F, "hunger9_en"));
      tbl.push_back(mk(134, 134, B_FEED, 1'b0, 16'h440F, "feed_again"));
      tbl.push_back(mk(140, 140, 5'b0,   1'b1, 16'h000F, "done_on_step"));
      tbl.push_back(mk(-1, 196, 5'b0,    1'b0, 16'h000F, "hunger7_after"));
      tbl.push_back(mk(-1, 204, 5'b0,    1'b0, 16'h060F, "hunger_bored_en"));
      tbl.push_back(mk(205, 205, B_PLAY, 1'b0, 16'h860F, "ball_pending"));

      @(posedge clk);
      #1;
      do_reset("reset_init");
      foreach (tbl[i]) begin
         pulse_chk(tbl[i].at, tbl[i].btn, tbl[i].done, tbl[i].chk, tbl[i].exp, tbl[i].name);
      end

      // Reset with a ball pending and enables high, then a cared-for pet falls asleep.
      do_reset("reset_mid_pend");
      refresh(8 * 12 - 3);
      refresh(8 * 24 - 3);
      refresh(8 * 35 - 3);
      pulse_chk(-1,  0,      1'b0, 308, 16'h000F, "awake_step39");
      pulse_chk(-1,  0,      1'b0, 316, 16'h002F, "asleep_step40");
      pulse_chk(320, B_FEED, 1'b0, 320, 16'h002F, "feed_asleep");
      pulse_chk(-1,  0,      1'b0, 392, 16'h002F, "frozen_sleep");
      pulse_chk(-1,  0,      1'b0, 396, 16'h000F, "wake");
      pulse_chk(-1,  0,      1'b0, 412, 16'h000F, "resume_hunger7");
      pulse_chk(-1,  0,      1'b0, 420, 16'h040F, "resume_hunger8");

      // Neglected pet: hunger saturates at step 15, health drains to zero at step 30.
      do_reset("reset_awake");
      pulse_chk(-1,  0,      1'b0, 196, 16'h0685, "health5");
      pulse_chk(-1,  0,      1'b0, 204, 16'h06C4, "dying_at4");
      pulse_chk(-1,  0,      1'b0, 228, 16'h06C1, "health1");
      pulse_chk(230, B_FEED, 1'b0, 230, 16'h46C1, "feed_before_death");
      pulse_chk(-1,  0,      1'b0, 236, 16'h0690, "deceased");
      pulse_chk(238, B_AID,  1'b0, 238, 16'h0690, "aid_ignored_dead");
      pulse_chk(-1,  0,      1'b0, 260, 16'h0690, "frozen_dead");
      do_reset("reset_dead");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
